// File: rtl/common_pkg.sv
// Shared types and constants for the multicycle controller: FSM states, opcode classes,
// opcode and ALU-op encodings, and the opcode classifier.
package common_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd5
  } ctrl_state_t;

  typedef enum logic [1:0] {
    CLS_R   = 2'd0,
    CLS_LD  = 2'd1,
    CLS_ST  = 2'd2,
    CLS_BEQ = 2'd3
  } instr_class_t;

  typedef struct packed {
    logic         legal;
    instr_class_t cls;
  } decode_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;

  function automatic decode_t decode_opcode(input logic [6:0] op);
    decode_t d;
    d.legal = 1'b1;
    d.cls   = CLS_R;
    case (op)
      OP_RTYPE:  d.cls = CLS_R;
      OP_LOAD:   d.cls = CLS_LD;
      OP_STORE:  d.cls = CLS_ST;
      OP_BRANCH: d.cls = CLS_BEQ;
      default:   d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle. master = controller, slave = datapath side.
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic [1:0] ctrl_ALU_op;
  logic       ALU_src;
  logic       ir_write;
  logic       pc_write;
  logic       pc_branch;
  logic       mem_req;
  logic       mem_we;
  logic       reg_write;
  logic       mem_to_reg;
  logic       instr_done;
  logic       illegal_instr;

  modport master (
    input  opcode, zero, mem_ready,
    output ctrl_ALU_op, ALU_src, ir_write, pc_write, pc_branch, mem_req, mem_we,
           reg_write, mem_to_reg, instr_done, illegal_instr
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  ctrl_ALU_op, ALU_src, ir_write, pc_write, pc_branch, mem_req, mem_we,
           reg_write, mem_to_reg, instr_done, illegal_instr
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Memory-wait watchdog: counts consecutive waiting cycles and flags the cycle in which the
// count, including the current cycle, reaches TIMEOUT_CYCLES.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting,
  output logic timeout
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (!waiting) begin
      count_d = 8'd0;
    end else if (count_q < LIMIT) begin
      count_d = count_q + 8'd1;
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign timeout = waiting && (count_q == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM: FETCH/DECODE/EXEC/MEM/WB with a sticky FAULT state
// entered on an illegal opcode or a memory-wait timeout.
module multicycle_ctrl
  import common_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic              clk,
  input logic              rst,
  multicycle_ctrl_if.master bus
);

  ctrl_state_t  state_q, state_d;
  instr_class_t cls_q, cls_d;
  decode_t      dec_s;
  logic         waiting_s;
  logic         timeout_s;

  logic [1:0] alu_op_s;
  logic       alu_src_s, ir_write_s, pc_write_s, pc_branch_s, mem_req_s, mem_we_s;
  logic       reg_write_s, mem_to_reg_s, instr_done_s, illegal_s;

  // Kept outside the FSM process so the watchdog path is not a combinational loop.
  assign waiting_s = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !bus.mem_ready;
  assign dec_s     = decode_opcode(bus.opcode);

  mem_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .waiting (waiting_s),
    .timeout (timeout_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
      cls_q   <= CLS_R;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    alu_op_s     = ALU_OP_ADD;
    alu_src_s    = 1'b0;
    ir_write_s   = 1'b0;
    pc_write_s   = 1'b0;
    pc_branch_s  = 1'b0;
    mem_req_s    = 1'b0;
    mem_we_s     = 1'b0;
    reg_write_s  = 1'b0;
    mem_to_reg_s = 1'b0;
    instr_done_s = 1'b0;
    illegal_s    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req_s = 1'b1;
        if (bus.mem_ready) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
          state_d    = ST_DECODE;
        end else if (timeout_s) begin
          state_d = ST_FAULT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        cls_d = dec_s.cls;
        if (dec_s.legal) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_FAULT;
        end
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_R: begin
            alu_op_s = ALU_OP_FUNCT;
            state_d  = ST_WB;
          end
          CLS_LD, CLS_ST: begin
            alu_op_s  = ALU_OP_ADD;
            alu_src_s = 1'b1;
            state_d   = ST_MEM;
          end
          CLS_BEQ: begin
            alu_op_s     = ALU_OP_BRANCH;
            pc_branch_s  = 1'b1;
            pc_write_s   = bus.zero;
            instr_done_s = 1'b1;
            state_d      = ST_FETCH;
          end
          default: state_d = ST_FAULT;
        endcase
      end
      ST_MEM: begin
        mem_req_s = 1'b1;
        mem_we_s  = (cls_q == CLS_ST);
        if (bus.mem_ready) begin
          if (cls_q == CLS_LD) begin
            state_d = ST_WB;
          end else begin
            instr_done_s = 1'b1;
            state_d      = ST_FETCH;
          end
        end else if (timeout_s) begin
          state_d = ST_FAULT;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = (cls_q == CLS_LD);
        instr_done_s = 1'b1;
        state_d      = ST_FETCH;
      end
      ST_FAULT: begin
        illegal_s = 1'b1;
        state_d   = ST_FAULT;
      end
      default: state_d = ST_FAULT;
    endcase
  end

  // Outputs are masked by rst so an asserted reset silences everything without a clock edge.
  assign bus.ctrl_ALU_op   = rst ? 2'b00 : alu_op_s;
  assign bus.ALU_src       = rst ? 1'b0  : alu_src_s;
  assign bus.ir_write      = rst ? 1'b0  : ir_write_s;
  assign bus.pc_write      = rst ? 1'b0  : pc_write_s;
  assign bus.pc_branch     = rst ? 1'b0  : pc_branch_s;
  assign bus.mem_req       = rst ? 1'b0  : mem_req_s;
  assign bus.mem_we        = rst ? 1'b0  : mem_we_s;
  assign bus.reg_write     = rst ? 1'b0  : reg_write_s;
  assign bus.mem_to_reg    = rst ? 1'b0  : mem_to_reg_s;
  assign bus.instr_done    = rst ? 1'b0  : instr_done_s;
  assign bus.illegal_instr = rst ? 1'b0  : illegal_s;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: inputs change and outputs are sampled just after the
// falling edge, so each check sees one state's decoded outputs.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Output bit order: alu[11:10] src irw pcw pcb mreq mwe rw m2r done ill
  function automatic logic [11:0] ev(input logic [1:0] alu, input logic src, input logic irw,
                                     input logic pcw, input logic pcb, input logic mreq,
                                     input logic mwe, input logic rw, input logic m2r,
                                     input logic done, input logic ill);
    return {alu, src, irw, pcw, pcb, mreq, mwe, rw, m2r, done, ill};
  endfunction

  function automatic logic [11:0] outs();
    return {bus.ctrl_ALU_op, bus.ALU_src, bus.ir_write, bus.pc_write, bus.pc_branch,
            bus.mem_req, bus.mem_we, bus.reg_write, bus.mem_to_reg, bus.instr_done,
            bus.illegal_instr};
  endfunction

  task automatic chk(input string tag, input logic [11:0] exp_v);
    logic [11:0] obs;
    obs = outs();
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input logic [6:0] op, input logic rdy, input logic z);
    @(negedge clk);
    bus.opcode    = op;
    bus.mem_ready = rdy;
    bus.zero      = z;
    #1;
  endtask

  logic [11:0] V_ZERO, V_FETCH_RDY, V_FETCH_WAIT, V_EXEC_R, V_WB_R, V_WB_LD, V_EXEC_MEM;
  logic [11:0] V_MEM_LD, V_MEM_ST, V_BEQ_T, V_BEQ_N, V_FAULT;

  initial begin
    V_ZERO       = 12'h000;
    V_FETCH_RDY  = ev(2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    V_FETCH_WAIT = ev(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    V_EXEC_R     = ev(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    V_WB_R       = ev(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    V_WB_LD      = ev(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    V_EXEC_MEM   = ev(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    V_MEM_LD     = V_FETCH_WAIT;
    V_MEM_ST     = ev(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    V_BEQ_T      = ev(2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    V_BEQ_N      = ev(2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    V_FAULT      = 12'h001;

    bus.opcode = 7'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk("reset_outputs", V_ZERO);

    // R-type, zero-wait memory: 4 cycles
    @(negedge clk); rst = 1'b0; bus.opcode = 7'b0110011; bus.mem_ready = 1'b1; #1;
    chk("r_fetch_first_cycle", V_FETCH_RDY);
    cyc(7'b0110011, 1'b1, 1'b0); chk("r_decode_ignores_ready", V_ZERO);
    cyc(7'b0110011, 1'b1, 1'b0); chk("r_exec", V_EXEC_R);
    cyc(7'b0110011, 1'b1, 1'b0); chk("r_wb", V_WB_R);

    // Load with 3 wait cycles in MEM: 8 cycles
    cyc(7'b0000011, 1'b1, 1'b0); chk("ld_fetch", V_FETCH_RDY);
    cyc(7'b0000011, 1'b1, 1'b0); chk("ld_decode", V_ZERO);
    cyc(7'b0000011, 1'b1, 1'b0); chk("ld_exec", V_EXEC_MEM);
    for (int i = 0; i < 3; i++) begin
      cyc(7'b0000011, 1'b0, 1'b0); chk("ld_mem_wait", V_MEM_LD);
    end
    cyc(7'b0000011, 1'b1, 1'b0); chk("ld_mem_ready", V_MEM_LD);
    cyc(7'b0000011, 1'b1, 1'b0); chk("ld_wb", V_WB_LD);

    // Store: 4 cycles, retires in MEM
    cyc(7'b0100011, 1'b1, 1'b0); chk("st_fetch", V_FETCH_RDY);
    cyc(7'b0100011, 1'b1, 1'b0); chk("st_decode", V_ZERO);
    cyc(7'b0100011, 1'b1, 1'b0); chk("st_exec", V_EXEC_MEM);
    cyc(7'b0100011, 1'b1, 1'b0); chk("st_mem", V_MEM_ST);

    // Branch taken, then zero flipped in the same EXEC cycle
    cyc(7'b1100011, 1'b1, 1'b1); chk("beq_t_fetch", V_FETCH_RDY);
    cyc(7'b1100011, 1'b1, 1'b1); chk("beq_t_decode", V_ZERO);
    cyc(7'b1100011, 1'b1, 1'b1); chk("beq_t_exec", V_BEQ_T);
    bus.zero = 1'b0; #1 chk("beq_zero_comb", V_BEQ_N);
    bus.zero = 1'b1; #1;

    // Branch not taken
    cyc(7'b1100011, 1'b1, 1'b0); chk("beq_n_fetch", V_FETCH_RDY);
    cyc(7'b1100011, 1'b1, 1'b0); chk("beq_n_decode", V_ZERO);
    cyc(7'b1100011, 1'b1, 1'b0); chk("beq_n_exec", V_BEQ_N);

    // Illegal opcode: sticky fault
    cyc(7'b1111111, 1'b1, 1'b0); chk("ill_fetch", V_FETCH_RDY);
    cyc(7'b1111111, 1'b1, 1'b0); chk("ill_decode", V_ZERO);
    for (int i = 0; i < 21; i++) begin
      cyc(7'b0110011, 1'(i % 2), 1'b0); chk("ill_fault_held", V_FAULT);
    end

    // Asynchronous reset mid-cycle clears the fault before any edge
    #1 rst = 1'b1; #1 chk("rst_async_fault", V_ZERO);

    // Watchdog in FETCH: 16 waiting cycles, then FAULT
    @(negedge clk); rst = 1'b0; bus.mem_ready = 1'b0; #1;
    chk("wd_fetch_1", V_FETCH_WAIT);
    for (int i = 1; i < 16; i++) begin
      cyc(7'b0110011, 1'b0, 1'b0); chk("wd_fetch_wait", V_FETCH_WAIT);
    end
    cyc(7'b0110011, 1'b0, 1'b0); chk("wd_fault", V_FAULT);

    // Reset mid-MEM of a store drops mem_req immediately; no retry afterwards
    @(negedge clk); rst = 1'b1; #1;
    @(negedge clk); rst = 1'b0; bus.opcode = 7'b0100011; bus.mem_ready = 1'b1; #1;
    chk("mr_fetch", V_FETCH_RDY);
    cyc(7'b0100011, 1'b1, 1'b0); chk("mr_decode", V_ZERO);
    cyc(7'b0100011, 1'b1, 1'b0); chk("mr_exec", V_EXEC_MEM);
    cyc(7'b0100011, 1'b0, 1'b0);
    chk("mr_mem_wait", ev(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    #1 rst = 1'b1; #1 chk("mr_rst_async", V_ZERO);
    @(negedge clk); rst = 1'b0; bus.mem_ready = 1'b0; #1;
    chk("mr_restart_fetch", V_FETCH_WAIT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, memory-wait watchdog limit in cycles (legal range 2..255).
REQ-002 SHALL have clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have opcode  input  7  instruction register opcode field, valid from DECODE onward.
REQ-005 SHALL have zero  input  1  ALU zero flag.
REQ-006 SHALL have mem_ready  input  1  memory completes the current mem_req this cycle.
REQ-007 SHALL have ctrl_ALU_op  output  2  to ALU_control: 00 add, 01 branch compare, 10 funct decode.
REQ-008 SHALL have ALU_src  output  1  1 selects immediate as ALU operand B.
REQ-009 SHALL have ir_write  output  1  load instruction register.
REQ-010 SHALL have pc_write  output  1  update PC.
REQ-011 SHALL have pc_branch  output  1  PC source: 0 = PC+4, 1 = branch target.
REQ-012 SHALL have mem_req  output  1  memory request, held until mem_ready.
REQ-013 SHALL have mem_we  output  1  1 = write request; valid only with mem_req.
REQ-014 SHALL have reg_write  output  1  register file write enable.
REQ-015 SHALL have mem_to_reg  output  1  writeback source: 1 = memory data.
REQ-016 SHALL have instr_done  output  1  one-cycle pulse on instruction retirement.
REQ-017 SHALL have illegal_instr  output  1  sticky fault flag.

Function
REQ-018 SHALL implement FSM states FETCH, DECODE, EXEC, MEM, WB, FAULT; all outputs decoded from state plus the opcode class latched in DECODE; pc_write in EXEC additionally depends combinationally on zero.
REQ-019 FETCH: mem_req=1, mem_we=0; on mem_ready: ir_write=1, pc_write=1, pc_branch=0, next DECODE; otherwise stay.
REQ-020 DECODE (1 cycle): latch class from opcode (0110011 R, 0000011 LD, 0100011 ST, 1100011 BEQ); any other opcode -> FAULT; otherwise -> EXEC.
REQ-021 EXEC (1 cycle): R: ctrl_ALU_op=10, ALU_src=0, -> WB; LD/ST: ctrl_ALU_op=00, ALU_src=1, -> MEM; BEQ: ctrl_ALU_op=01, ALU_src=0, pc_branch=1, pc_write=zero, instr_done=1, -> FETCH.
REQ-022 MEM: mem_req=1, mem_we=(ST); on mem_ready: LD -> WB, ST -> instr_done=1, -> FETCH; otherwise stay.
REQ-023 WB (1 cycle): reg_write=1, mem_to_reg=(LD), instr_done=1, -> FETCH.
REQ-024 Outside EXEC, ctrl_ALU_op SHALL be 00 and ALU_src 0; all other unlisted outputs 0 in every state.
REQ-025 Minimum latency with zero-wait memory: BEQ 3, R 4, ST 4, LD 5 cycles, FETCH to FETCH.
REQ-026 Watchdog: counter increments each cycle in FETCH or MEM with mem_ready=0, clears on mem_ready or state change; reaching TIMEOUT_CYCLES -> FAULT next edge.
REQ-027 FAULT: illegal_instr=1, all enables and mem_req 0; exit only via rst.
REQ-028 mem_ready outside FETCH/MEM SHALL be ignored.

Reset
REQ-029 rst assertion SHALL immediately force state FETCH-pending-release, all outputs 0, watchdog 0, illegal_instr 0, without waiting for clk.
REQ-030 rst mid-MEM SHALL drop mem_req asynchronously; the aborted transaction is not retried and no instr_done is generated.
REQ-031 First mem_req SHALL assert in the first cycle after rst deasserts.

Structure
REQ-032 common_pkg SHALL hold ctrl_state_t enum, opcode localparams (OP_RTYPE, OP_LOAD, OP_STORE, OP_BRANCH) and ALU_op localparams (ALU_OP_ADD, ALU_OP_BRANCH, ALU_OP_FUNCT).
REQ-033 Watchdog SHALL be a sub-module mem_wait_timer (inputs clk, rst, waiting; output timeout; parameter TIMEOUT_CYCLES).

Verification
REQ-034 opcode 0110011, mem_ready=1 -> ctrl_ALU_op=10 in cycle 3, reg_write=1 and mem_to_reg=0 and instr_done=1 in cycle 4.
REQ-035 opcode 0000011, mem_ready low 3 cycles in MEM -> mem_req held 4 cycles, mem_we=0, WB with mem_to_reg=1, 8 cycles total.
REQ-036 opcode 0100011 -> mem_we=1 in MEM, reg_write never 1, instr_done on MEM completion, 4 cycles.
REQ-037 opcode 1100011: zero=1 -> pc_write=1, pc_branch=1 in EXEC; zero=0 -> pc_branch=1, pc_write=0; both retire in 3 cycles.
REQ-038 opcode 1111111 -> illegal_instr=1 from the cycle after DECODE, held through 20 further cycles until rst.
REQ-039 mem_ready=0 for 16 cycles in FETCH (TIMEOUT_CYCLES=16) -> FAULT; rst pulse mid-MEM -> all outputs 0 before next clk edge.
